// File: rtl/breg_pkg.sv
// Shared definitions for the VGA color register bank write-port scheduler.
package breg_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Default bank geometry and clear value.
  localparam int unsigned BIT_ADDR_DEF  = 4;
  localparam int unsigned BIT_DATO_DEF  = 3;
  localparam int unsigned CLR_VALUE_DEF = 0;

endpackage : breg_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: when both requesters are valid, ptr picks the winner.
module rr_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic ptr,
  output logic gnt,
  output logic any
);

  // gnt=1 selects requester 1: either it is alone or it holds the round-robin turn.
  always_comb begin
    gnt = v1 & (~v0 | ptr);
    any = v0 | v1;
  end

endmodule : rr_arb2

// File: rtl/breg_write_sched.sv
// Write-port scheduler for the color register bank: arbitrates two requesters
// onto one write port and runs a full-bank clear sequence.
module breg_write_sched
  import breg_pkg::*;
#(
  parameter int unsigned BIT_ADDR  = BIT_ADDR_DEF,
  parameter int unsigned BIT_DATO  = BIT_DATO_DEF,
  parameter int unsigned CLR_VALUE = CLR_VALUE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [BIT_ADDR-1:0] req0_addr,
  input  logic [BIT_DATO-1:0] req0_dat,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [BIT_ADDR-1:0] req1_addr,
  input  logic [BIT_DATO-1:0] req1_dat,
  output logic                req1_ready,
  input  logic                clr_req,
  output logic                clr_done,
  output logic                busy,
  output logic [BIT_ADDR-1:0] addrW,
  output logic [BIT_DATO-1:0] datW,
  output logic                RegWrite
);

  localparam logic [BIT_DATO-1:0] CLR_DAT  = BIT_DATO'(CLR_VALUE);
  localparam logic [BIT_ADDR-1:0] CLR_LAST = '1;

  state_t              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                grant_q, grant_d;
  logic [BIT_ADDR-1:0] clr_cnt_q, clr_cnt_d;

  logic                regwrite_q, regwrite_d;
  logic [BIT_ADDR-1:0] addrw_q, addrw_d;
  logic [BIT_DATO-1:0] datw_q, datw_d;
  logic                ready0_q, ready0_d;
  logic                ready1_q, ready1_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                arb_gnt;
  logic                arb_any;

  rr_arb2 u_arb (
    .v0  (req0_valid),
    .v1  (req1_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  // Next state plus next value of every output register. Outputs are computed
  // for the state being entered so that the bus shows a write during the
  // WRITE/CLEAR cycle itself while staying fully registered.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    clr_cnt_d  = clr_cnt_q;
    regwrite_d = 1'b0;
    addrw_d    = '0;
    datw_d     = '0;
    ready0_d   = 1'b0;
    ready1_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d    = ST_CLEAR;
          clr_cnt_d  = '0;
          regwrite_d = 1'b1;
          addrw_d    = '0;
          datw_d     = CLR_DAT;
          busy_d     = 1'b1;
        end else if (arb_any) begin
          state_d    = ST_WRITE;
          grant_d    = arb_gnt;
          regwrite_d = 1'b1;
          addrw_d    = arb_gnt ? req1_addr : req0_addr;
          datw_d     = arb_gnt ? req1_dat  : req0_dat;
          ready0_d   = ~arb_gnt;
          ready1_d   = arb_gnt;
          busy_d     = 1'b1;
        end
      end
      ST_WRITE: begin
        rr_ptr_d = ~grant_q;
        state_d  = ST_IDLE;
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          clr_cnt_d  = clr_cnt_q + 1'b1;
          regwrite_d = 1'b1;
          addrw_d    = clr_cnt_q + 1'b1;
          datw_d     = CLR_DAT;
          busy_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 1'b0;
      grant_q    <= 1'b0;
      clr_cnt_q  <= '0;
      regwrite_q <= 1'b0;
      addrw_q    <= '0;
      datw_q     <= '0;
      ready0_q   <= 1'b0;
      ready1_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      clr_cnt_q  <= clr_cnt_d;
      regwrite_q <= regwrite_d;
      addrw_q    <= addrw_d;
      datw_q     <= datw_d;
      ready0_q   <= ready0_d;
      ready1_q   <= ready1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign RegWrite   = regwrite_q;
  assign addrW      = addrw_q;
  assign datW       = datw_q;
  assign req0_ready = ready0_q;
  assign req1_ready = ready1_q;
  assign busy       = busy_q;
  assign clr_done   = done_q;

endmodule : breg_write_sched

// File: tb/tb_breg_write_sched.sv
// Self-checking bench for breg_write_sched against a transaction-level model.
module tb_breg_write_sched;

  localparam int NREG = 16;
  localparam logic [2:0] CLRV = 3'd0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, clr_req = 1'b0;
  logic [3:0] req0_addr = '0, req1_addr = '0;
  logic [2:0] req0_dat = '0, req1_dat = '0;
  logic       req0_ready, req1_ready, clr_done, busy, RegWrite;
  logic [3:0] addrW;
  logic [2:0] datW;

  int checks = 0;
  int errors = 0;

  // Model state: writes left in a clear, pending write shown, who is favoured.
  int  m_clr_left = 0;
  bit  m_in_write = 0;
  int  m_fav = 0;
  int  m_who = 0;
  logic [11:0] exp_v = '0;
  logic [11:0] obs_v;

  breg_write_sched #(.BIT_ADDR(4), .BIT_DATO(3), .CLR_VALUE(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_dat(req0_dat), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_dat(req1_dat), .req1_ready(req1_ready),
    .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
    .addrW(addrW), .datW(datW), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  // Vector layout: {RegWrite, addrW[3:0], datW[2:0], ready0, ready1, busy, clr_done}
  function automatic logic [11:0] pk(input logic rw, input logic [3:0] a, input logic [2:0] d,
                                     input logic r0, input logic r1, input logic b, input logic dn);
    return {rw, a, d, r0, r1, b, dn};
  endfunction

  // Advance one clock, update the model from the inputs seen at the edge, sample the DUT.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_clr_left = 0; m_in_write = 0; m_fav = 0; exp_v = '0;
    end else if (m_clr_left > 0) begin
      m_clr_left--;
      if (m_clr_left > 0) exp_v = pk(1'b1, 4'(NREG - m_clr_left), CLRV, 1'b0, 1'b0, 1'b1, 1'b0);
      else                exp_v = pk(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    end else if (m_in_write) begin
      m_in_write = 0;
      m_fav = 1 - m_who;
      exp_v = '0;
    end else if (clr_req) begin
      m_clr_left = NREG;
      exp_v = pk(1'b1, 4'd0, CLRV, 1'b0, 1'b0, 1'b1, 1'b0);
    end else if (req0_valid || req1_valid) begin
      m_who = (req0_valid && req1_valid) ? m_fav : (req1_valid ? 1 : 0);
      m_in_write = 1;
      exp_v = pk(1'b1, m_who == 1 ? req1_addr : req0_addr, m_who == 1 ? req1_dat : req0_dat,
                 m_who == 0, m_who == 1, 1'b1, 1'b0);
    end else begin
      exp_v = '0;
    end
    #1;
    obs_v = {RegWrite, addrW, datW, req0_ready, req1_ready, busy, clr_done};
  endtask

  task automatic apply_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; clr_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    if (obs_v !== 12'h000) begin
      errors++; $display("FAIL reset: got %h expected %h", obs_v, 12'h000);
    end
    checks++;
    tick();
    if (obs_v !== exp_v) begin
      errors++; $display("FAIL reset_idle: got %h expected %h", obs_v, exp_v);
    end
    checks++;
  endtask

  task automatic test_single();
    apply_reset();
    req0_valid = 1'b1; req0_addr = 4'd5; req0_dat = 3'b110;
    tick();
    if ({RegWrite, addrW, datW, req0_ready, req1_ready} !== {1'b1, 4'd5, 3'd6, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_write: got %h expected %h", obs_v, exp_v);
    end
    checks++;
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL single_after cyc%0d: got %h expected %h", i, obs_v, exp_v);
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen[$];
    apply_reset();
    req0_valid = 1'b1; req0_addr = 4'd1; req0_dat = 3'd1;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_dat = 3'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL alternate cyc%0d: got %h expected %h", i, obs_v, exp_v);
      end
      checks++;
      if (RegWrite) seen.push_back(addrW);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (seen.size() != 4 || seen[0] !== 4'd1 || seen[1] !== 4'd2 || seen[2] !== 4'd1 || seen[3] !== 4'd2) begin
      errors++; $display("FAIL alternate_order: got %0d writes first %h expected 4 writes 1,2,1,2",
                         seen.size(), seen.size() > 0 ? seen[0] : 4'hx);
    end
    checks++;
    tick();
  endtask

  task automatic test_clear();
    int nw = 0, nd = 0;
    apply_reset();
    clr_req = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      clr_req = 1'b0;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL clear cyc%0d: got %h expected %h", i, obs_v, exp_v);
      end
      checks++;
      if (RegWrite) nw++;
      if (clr_done) nd++;
    end
    if (nw != NREG || nd != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL clear_totals: got writes=%0d done=%0d busy=%b expected 16 1 0", nw, nd, busy);
    end
    checks++;
  endtask

  task automatic test_clear_stall();
    int done_at = -1, rdy_at = -1;
    apply_reset();
    clr_req = 1'b1;
    for (int i = 0; i < 40 && rdy_at < 0; i++) begin
      tick();
      clr_req = 1'b0;
      if (i == 2) begin req1_valid = 1'b1; req1_addr = 4'd9; req1_dat = 3'd3; end
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL stall cyc%0d: got %h expected %h", i, obs_v, exp_v);
      end
      checks++;
      if (clr_done) done_at = i;
      if (req1_ready) begin rdy_at = i; req1_valid = 1'b0; end
    end
    if (rdy_at < 0 || done_at < 0 || rdy_at != done_at + 1) begin
      errors++; $display("FAIL stall_timing: got done=%0d ready=%0d expected ready one cycle after done",
                         done_at, rdy_at);
    end
    checks++;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    bit hit = 0;
    int nd = 0;
    apply_reset();
    clr_req = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      clr_req = 1'b0;
      if (exp_v[10:7] == 4'd7 && exp_v[11]) hit = 1;
    end
    if (!hit) begin
      errors++; $display("FAIL rst_mid_reach: got no addrW=7 expected clear to reach 7");
    end
    checks++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if ({RegWrite, busy, addrW} !== {1'b0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL rst_mid: got rw=%b busy=%b addr=%h expected 0 0 0", RegWrite, busy, addrW);
    end
    checks++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL rst_mid_after cyc%0d: got %h expected %h", i, obs_v, exp_v);
      end
      checks++;
      if (clr_done) nd++;
    end
    if (nd != 0) begin
      errors++; $display("FAIL rst_mid_done: got %0d done pulses expected 0", nd);
    end
    checks++;
  endtask

  task automatic test_clear_beats_req();
    bit served = 0, done_seen = 0;
    apply_reset();
    clr_req = 1'b1;
    req0_valid = 1'b1; req0_addr = 4'd11; req0_dat = 3'd5;
    for (int i = 0; i < 30 && !served; i++) begin
      tick();
      clr_req = 1'b0;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL clr_first cyc%0d: got %h expected %h", i, obs_v, exp_v);
      end
      checks++;
      if (clr_done) done_seen = 1;
      if (req0_ready) begin
        served = 1;
        req0_valid = 1'b0;
        if (!done_seen || addrW !== 4'd11 || datW !== 3'd5) begin
          errors++; $display("FAIL clr_first_data: got done=%b addr=%h dat=%h expected 1 b 5",
                             done_seen, addrW, datW);
        end
        checks++;
      end
    end
    if (!served) begin
      errors++; $display("FAIL clr_first_timeout: got no req0_ready expected one within 30 cycles");
      checks++;
    end
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      tick();
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL random cyc%0d: got %h expected %h", i, obs_v, exp_v);
      end
      checks++;
      rst = ($urandom_range(0, 79) == 0);
      clr_req = ($urandom_range(0, 23) == 0);
      // Requesters hold their request until the model says it was accepted.
      if (exp_v[3] || rst) req0_valid = 1'b0;
      if (exp_v[2] || rst) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1; req0_addr = 4'($urandom); req0_dat = 3'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1; req1_addr = 4'($urandom); req1_dat = 3'($urandom);
      end
    end
    rst = 1'b0; clr_req = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_clear_stall();
    test_reset_mid_clear();
    test_clear_beats_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_breg_write_sched
